// File: rtl/multicycle_alu_sequencer.sv
// rtl/multicycle_alu_sequencer.sv - multicycle control FSM for a shared-datapath MIPS-style core
module multicycle_alu_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t cur_state;
    state_t nxt_state;
    logic   funct_legal;
    logic [3:0] funct_alu;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = ALU_AND;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_legal = 1'b0;
        endcase
    end

    assign state = cur_state;

    always_comb begin
        nxt_state   = FETCH;
        alu_control = 4'b0000;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        i_or_d      = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        pc_src      = 2'b00;
        pc_write    = 1'b0;
        illegal_op  = 1'b0;
        case (cur_state)
            IDLE: nxt_state = FETCH;
            FETCH: begin
                alu_src_b   = 2'b01;
                alu_control = ALU_ADD;
                ir_write    = 1'b1;
                pc_write    = 1'b1;
                nxt_state   = DECODE;
            end
            DECODE: begin
                // ALU precomputes the branch target into ALUOut while decoding
                alu_src_b   = 2'b11;
                alu_control = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: nxt_state = MEMADR;
                    OP_R: begin
                        if (funct_legal) begin
                            nxt_state = EXEC;
                        end else begin
                            illegal_op = 1'b1;
                        end
                    end
                    OP_BEQ:  nxt_state = BRANCH;
                    OP_ADDI: nxt_state = ADDIEX;
                    OP_J:    nxt_state = JUMP;
                    default: illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
                nxt_state   = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                i_or_d    = 1'b1;
                nxt_state = MEMWB;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            MEMWR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = funct_alu;
                nxt_state   = ALUWB;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                pc_write    = zero;
            end
            ADDIEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
                nxt_state   = ADDIWB;
            end
            ADDIWB: reg_write = 1'b1;
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: nxt_state = FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_alu_sequencer.sv
// tb/tb_multicycle_alu_sequencer.sv - randomized self-checking bench for multicycle_alu_sequencer
module tb_multicycle_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic [3:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       i_or_d, ir_write, mem_write, reg_write, reg_dst, mem_to_reg;
    logic [1:0] pc_src;
    logic       pc_write, illegal_op;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    int          exp_st[$];
    logic [16:0] exp_o[$];
    int          obs_st[$];
    logic [16:0] obs_o[$];

    multicycle_alu_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .i_or_d(i_or_d), .ir_write(ir_write), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .pc_src(pc_src), .pc_write(pc_write), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    // {alu_control, src_a, src_b, i_or_d, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, pc_src, pc_write, illegal_op}
    function automatic logic [16:0] dut_vec();
        return {alu_control, alu_src_a, alu_src_b, i_or_d, ir_write, mem_write,
                reg_write, reg_dst, mem_to_reg, pc_src, pc_write, illegal_op};
    endfunction

    function automatic logic [16:0] mk(input logic [3:0] alu, input logic sa, input logic [1:0] sb,
                                       input logic iod, input logic irw, input logic mw, input logic rw,
                                       input logic rd, input logic m2r, input logic [1:0] ps,
                                       input logic pw, input logic ill);
        return {alu, sa, sb, iod, irw, mw, rw, rd, m2r, ps, pw, ill};
    endfunction

    function automatic logic [3:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            default:   return 4'b0111;
        endcase
    endfunction

    function automatic logic [16:0] exp_vec(input int s, input logic [5:0] fn, input logic z, input logic ill);
        case (s)
            1:  return mk(4'b0010, 0, 2'b01, 0, 1, 0, 0, 0, 0, 2'b00, 1, 0);
            2:  return mk(4'b0010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, ill);
            3:  return mk(4'b0010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
            4:  return mk(4'b0000, 0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
            5:  return mk(4'b0000, 0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b00, 0, 0);
            6:  return mk(4'b0000, 0, 2'b00, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0);
            7:  return mk(r_alu(fn), 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
            8:  return mk(4'b0000, 0, 2'b00, 0, 0, 0, 1, 1, 0, 2'b00, 0, 0);
            9:  return mk(4'b0110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, z, 0);
            10: return mk(4'b0010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
            11: return mk(4'b0000, 0, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0);
            12: return mk(4'b0000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0);
            default: return 17'd0;
        endcase
    endfunction

    // Expected state walk per instruction class, then the per-state output table
    task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        int seq[$];
        logic ill;
        ill = 1'b0;
        exp_st.delete();
        exp_o.delete();
        case (op)
            6'b000000: begin
                if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) seq = {1, 2, 7, 8};
                else begin seq = {1, 2}; ill = 1'b1; end
            end
            6'b100011: seq = {1, 2, 3, 4, 5};
            6'b101011: seq = {1, 2, 3, 6};
            6'b000100: seq = {1, 2, 9};
            6'b001000: seq = {1, 2, 10, 11};
            6'b000010: seq = {1, 2, 12};
            default: begin seq = {1, 2}; ill = 1'b1; end
        endcase
        foreach (seq[i]) begin
            exp_st.push_back(seq[i]);
            exp_o.push_back(exp_vec(seq[i], fn, z, ill));
        end
    endtask

    // Real opcode/funct only where the decoder may look; random junk elsewhere
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int abort_idx);
        model_instr(op, fn, z);
        obs_st.delete();
        obs_o.delete();
        for (int i = 0; i < exp_st.size(); i++) begin
            @(posedge clk);
            #1;
            if (exp_st[i] inside {2, 3, 7}) begin
                opcode = op;
                funct  = fn;
            end else begin
                opcode = 6'($urandom);
                funct  = 6'($urandom);
            end
            zero = (exp_st[i] == 9) ? z : 1'($urandom);
            @(negedge clk);
            obs_st.push_back(int'(state));
            obs_o.push_back(dut_vec());
            if (i == abort_idx) break;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (state !== 4'd0 || dut_vec() !== 17'd0) begin
            errors++;
            $display("FAIL reset_held: state=%0d outs=%h, expected state=0 outs=0", state, dut_vec());
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 4'd0 || dut_vec() !== 17'd0) begin
            errors++;
            $display("FAIL reset_idle: state=%0d outs=%h, expected state=0 outs=0", state, dut_vec());
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fns[5] = '{6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101};
        foreach (fns[k]) begin
            run_instr(6'b000000, fns[k], 1'b0, -1);
            foreach (exp_st[i]) begin
                checks++;
                if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
                    errors++;
                    $display("FAIL rtype fn=%b cycle %0d: state=%0d outs=%h, expected state=%0d outs=%h",
                             fns[k], i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
                end
            end
        end
    endtask

    task automatic test_load_store();
        logic [5:0] ops[2] = '{6'b100011, 6'b101011};
        foreach (ops[k]) begin
            run_instr(ops[k], 6'($urandom), 1'b0, -1);
            foreach (exp_st[i]) begin
                checks++;
                if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
                    errors++;
                    $display("FAIL loadstore op=%b cycle %0d: state=%0d outs=%h, expected state=%0d outs=%h",
                             ops[k], i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
                end
            end
        end
    endtask

    task automatic test_branch();
        for (int z = 1; z >= 0; z--) begin
            run_instr(6'b000100, 6'($urandom), 1'(z), -1);
            foreach (exp_st[i]) begin
                checks++;
                if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
                    errors++;
                    $display("FAIL branch zero=%0d cycle %0d: state=%0d outs=%h, expected state=%0d outs=%h",
                             z, i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops[3] = '{6'b111111, 6'b000000, 6'b000000};
        logic [5:0] fns[3] = '{6'b100000, 6'b000000, 6'b111111};
        foreach (ops[k]) begin
            run_instr(ops[k], fns[k], 1'b1, -1);
            foreach (exp_st[i]) begin
                checks++;
                if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
                    errors++;
                    $display("FAIL illegal op=%b fn=%b cycle %0d: state=%0d outs=%h, expected state=%0d outs=%h",
                             ops[k], fns[k], i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midinstr();
        run_instr(6'b101011, 6'($urandom), 1'b0, 3);
        checks++;
        if (obs_st.size() != 4 || obs_st[3] !== 6 || obs_o[3] !== exp_o[3]) begin
            errors++;
            $display("FAIL memwr_before_reset: state=%0d outs=%h, expected state=6 outs=%h",
                     obs_st[obs_st.size()-1], obs_o[obs_o.size()-1], exp_o[3]);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || dut_vec() !== 17'd0) begin
            errors++;
            $display("FAIL async_reset: state=%0d outs=%h, expected state=0 outs=0", state, dut_vec());
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 4'd0 || dut_vec() !== 17'd0) begin
            errors++;
            $display("FAIL reset_restart_idle: state=%0d outs=%h, expected state=0 outs=0", state, dut_vec());
        end
        run_instr(6'b000010, 6'($urandom), 1'b0, -1);
        foreach (exp_st[i]) begin
            checks++;
            if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
                errors++;
                $display("FAIL jump cycle %0d: state=%0d outs=%h, expected state=%0d outs=%h",
                         i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
        logic [5:0] fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [5:0] op, fn;
        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_instr(op, fn, 1'($urandom), -1);
            foreach (exp_st[i]) begin
                checks++;
                if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
                    errors++;
                    $display("FAIL random op=%b fn=%b cycle %0d: state=%0d outs=%h, expected state=%0d outs=%h",
                             op, fn, i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_store();
        test_branch();
        test_illegal();
        test_reset_midinstr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
